// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and a selectable combinational or registered read port.
module sync_fifo_buf #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 512,
    parameter int ADDR_WIDTH    = 9,
    parameter int AFULL_THRESH  = 480,
    parameter int AEMPTY_THRESH = 32,
    parameter int READ_LATENCY  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr, rptr;
    logic [ADDR_WIDTH:0]   wptr_nxt, rptr_nxt, count_nxt;
    logic                  wacc, racc;

    // The extra wrap bit keeps the pointer difference an exact occupancy, 0..DEPTH.
    always_comb begin
        wacc      = w_en & ~full;
        racc      = r_en & ~empty;
        wptr_nxt  = wptr + {{ADDR_WIDTH{1'b0}}, wacc};
        rptr_nxt  = rptr + {{ADDR_WIDTH{1'b0}}, racc};
        count_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            // A new error in the same cycle as clr_err must not be lost.
            overflow     <= (w_en & full)  | (overflow  & ~clr_err);
            underflow    <= (r_en & empty) | (underflow & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wacc)
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    generate
        if (READ_LATENCY == 0) begin : g_show_ahead
            assign data_out = mem[rptr[ADDR_WIDTH-1:0]];
            assign rd_valid = ~empty;
        end else begin : g_registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= racc;
                    if (racc)
                        data_out <= mem[rptr[ADDR_WIDTH-1:0]];
                end
            end
        end
    endgenerate

endmodule
